// File: rtl/stack_pkg.sv
// Shared defaults and command priority encoding for the operand stack.
// The controller bench uses the same CMD_* codes.
package stack_pkg;
  localparam int STACK_WIDTH = 8;
  localparam int STACK_DEPTH = 16;

  localparam logic [2:0] CMD_IDLE    = 3'd0;
  localparam logic [2:0] CMD_REPLACE = 3'd1;
  localparam logic [2:0] CMD_POP     = 3'd2;
  localparam logic [2:0] CMD_TOS     = 3'd3;
  localparam logic [2:0] CMD_PUSH    = 3'd4;

  // Highest-priority command wins. A push that accompanies tos (no pop)
  // is still carried out by the stack itself.
  function automatic logic [2:0] cmd_decode(input logic push, input logic pop,
                                            input logic tos);
    if (push && pop) return CMD_REPLACE;
    if (pop)         return CMD_POP;
    if (tos)         return CMD_TOS;
    if (push)        return CMD_PUSH;
    return CMD_IDLE;
  endfunction
endpackage

// File: rtl/stack_regfile.sv
// DEPTH x WIDTH storage: one synchronous write port, one asynchronous read port.
// Contents are not reset.
module stack_regfile #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;

  assign rdata = mem[raddr];
endmodule

// File: rtl/stack_unit.sv
// Operand stack for the multicycle stack CPU: pointer, command decode,
// registered pop/TOS output and sticky overflow/underflow flags.
module stack_unit import stack_pkg::*; #(
  parameter int WIDTH = STACK_WIDTH,
  parameter int DEPTH = STACK_DEPTH,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             tos,
  input  logic [WIDTH-1:0] din,
  input  logic             err_clr,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full,
  output logic [PTR_W:0]   count,
  output logic             ovf_err,
  output logic             udf_err
);
  logic [PTR_W:0]   sp, sp_nxt;
  logic [PTR_W-1:0] top_addr, waddr;
  logic [WIDTH-1:0] rdata;
  logic             we, dout_ld, udf_set, ovf_set;
  logic [2:0]       cmd;

  assign count    = sp;
  assign empty    = (sp == '0);
  assign full     = (sp == (PTR_W+1)'(DEPTH));
  // At sp==DEPTH the low bits are zero, so the decrement lands on DEPTH-1.
  assign top_addr = sp[PTR_W-1:0] - 1'b1;
  assign cmd      = cmd_decode(push, pop, tos);

  stack_regfile #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_rf (
    .clk  (clk),
    .we   (we),
    .waddr(waddr),
    .wdata(din),
    .raddr(top_addr),
    .rdata(rdata)
  );

  always_comb begin
    we      = 1'b0;
    waddr   = sp[PTR_W-1:0];
    sp_nxt  = sp;
    dout_ld = 1'b0;
    udf_set = 1'b0;
    ovf_set = 1'b0;
    case (cmd)
      CMD_REPLACE: begin
        we = 1'b1;
        if (!empty) begin
          dout_ld = 1'b1;
          waddr   = top_addr;
        end else begin
          // Nothing to pop: degrade to a plain push (an empty stack is never full).
          udf_set = 1'b1;
          sp_nxt  = sp + 1'b1;
        end
      end
      CMD_POP: begin
        if (!empty) begin
          dout_ld = 1'b1;
          sp_nxt  = sp - 1'b1;
        end else udf_set = 1'b1;
      end
      CMD_TOS: begin
        if (!empty) dout_ld = 1'b1;
        else        udf_set = 1'b1;
        if (push) begin
          if (!full) begin
            we     = 1'b1;
            sp_nxt = sp + 1'b1;
          end else ovf_set = 1'b1;
        end
      end
      CMD_PUSH: begin
        if (!full) begin
          we     = 1'b1;
          sp_nxt = sp + 1'b1;
        end else ovf_set = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sp      <= '0;
      dout    <= '0;
      ovf_err <= 1'b0;
      udf_err <= 1'b0;
    end else begin
      sp <= sp_nxt;
      if (dout_ld) dout <= rdata;
      if (udf_set)      udf_err <= 1'b1;
      else if (err_clr) udf_err <= 1'b0;
      if (ovf_set)      ovf_err <= 1'b1;
      else if (err_clr) ovf_err <= 1'b0;
    end
  end
endmodule

// File: tb/tb_stack_unit.sv
// Directed bench for stack_unit: each scenario task drives one feature and checks inline.
module tb_stack_unit;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       push = 1'b0, pop = 1'b0, tos = 1'b0, err_clr = 1'b0;
  logic [7:0] din = 8'h00;
  logic [7:0] dout;
  logic       empty, full, ovf_err, udf_err;
  logic [4:0] count;
  int checks = 0;
  int failures = 0;

  stack_unit dut (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .tos(tos), .din(din),
    .err_clr(err_clr), .dout(dout), .empty(empty), .full(full),
    .count(count), .ovf_err(ovf_err), .udf_err(udf_err)
  );

  always #5 clk = ~clk;

  // One clock with the given strobes; outputs are sampled 1ns after the edge.
  task automatic cyc(input logic p, input logic po, input logic t,
                     input logic [7:0] d, input logic c);
    push = p; pop = po; tos = t; din = d; err_clr = c;
    @(posedge clk); #1;
    push = 1'b0; pop = 1'b0; tos = 1'b0; err_clr = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (dout !== 8'h00) begin failures++; $display("FAIL reset_dout got=%h exp=00", dout); end
    checks++; if (count !== 5'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++; if (empty !== 1'b1 || full !== 1'b0) begin failures++; $display("FAIL reset_flags empty=%b full=%b exp=1/0", empty, full); end
    checks++; if (ovf_err !== 1'b0 || udf_err !== 1'b0) begin failures++; $display("FAIL reset_err ovf=%b udf=%b exp=0/0", ovf_err, udf_err); end
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_push_pop;
    cyc(1, 0, 0, 8'h11, 0);
    cyc(1, 0, 0, 8'h22, 0);
    cyc(1, 0, 0, 8'h33, 0);
    checks++; if (count !== 5'd3) begin failures++; $display("FAIL pp_count3 got=%0d exp=3", count); end
    checks++; if (dout !== 8'h00) begin failures++; $display("FAIL pp_dout_nopop got=%h exp=00", dout); end
    cyc(0, 1, 0, 8'h00, 0);
    checks++; if (dout !== 8'h33) begin failures++; $display("FAIL pp_pop1 got=%h exp=33", dout); end
    cyc(0, 1, 0, 8'h00, 0);
    checks++; if (dout !== 8'h22) begin failures++; $display("FAIL pp_pop2 got=%h exp=22", dout); end
    checks++; if (count !== 5'd1 || empty !== 1'b0) begin failures++; $display("FAIL pp_count1 count=%0d empty=%b exp=1/0", count, empty); end
    cyc(0, 1, 0, 8'h00, 0);
    checks++; if (dout !== 8'h11 || empty !== 1'b1) begin failures++; $display("FAIL pp_pop3 dout=%h empty=%b exp=11/1", dout, empty); end
  endtask

  task automatic test_tos;
    cyc(1, 0, 0, 8'h5A, 0);
    cyc(0, 0, 1, 8'h00, 0);
    checks++; if (dout !== 8'h5A || count !== 5'd1) begin failures++; $display("FAIL tos1 dout=%h count=%0d exp=5a/1", dout, count); end
    cyc(0, 0, 1, 8'h00, 0);
    checks++; if (dout !== 8'h5A || count !== 5'd1) begin failures++; $display("FAIL tos2 dout=%h count=%0d exp=5a/1", dout, count); end
    cyc(0, 1, 0, 8'h00, 0);
    checks++; if (dout !== 8'h5A || empty !== 1'b1) begin failures++; $display("FAIL tos_pop dout=%h empty=%b exp=5a/1", dout, empty); end
  endtask

  task automatic test_underflow;
    cyc(0, 1, 0, 8'h00, 0);
    checks++; if (udf_err !== 1'b1 || count !== 5'd0) begin failures++; $display("FAIL udf_pop udf=%b count=%0d exp=1/0", udf_err, count); end
    cyc(0, 0, 1, 8'h00, 0);
    checks++; if (dout !== 8'h5A || udf_err !== 1'b1) begin failures++; $display("FAIL udf_tos dout=%h udf=%b exp=5a/1", dout, udf_err); end
    cyc(0, 0, 0, 8'h00, 1);
    checks++; if (udf_err !== 1'b0) begin failures++; $display("FAIL udf_clr got=%b exp=0", udf_err); end
    // New error in the same cycle as err_clr: the set wins.
    cyc(0, 1, 0, 8'h00, 1);
    checks++; if (udf_err !== 1'b1) begin failures++; $display("FAIL udf_set_wins got=%b exp=1", udf_err); end
    cyc(0, 0, 0, 8'h00, 1);
    checks++; if (udf_err !== 1'b0 || ovf_err !== 1'b0) begin failures++; $display("FAIL udf_clr2 udf=%b ovf=%b exp=0/0", udf_err, ovf_err); end
  endtask

  task automatic test_full;
    for (int i = 0; i < 16; i++) cyc(1, 0, 0, 8'(i), 0);
    checks++; if (full !== 1'b1 || count !== 5'd16) begin failures++; $display("FAIL full_flag full=%b count=%0d exp=1/16", full, count); end
    cyc(1, 0, 0, 8'hFF, 0);
    checks++; if (ovf_err !== 1'b1 || count !== 5'd16) begin failures++; $display("FAIL ovf ovf=%b count=%0d exp=1/16", ovf_err, count); end
    cyc(0, 1, 0, 8'h00, 0);
    checks++; if (dout !== 8'h0F || count !== 5'd15 || full !== 1'b0) begin failures++; $display("FAIL full_pop dout=%h count=%0d full=%b exp=0f/15/0", dout, count, full); end
    cyc(0, 0, 0, 8'h00, 1);
    checks++; if (ovf_err !== 1'b0) begin failures++; $display("FAIL ovf_clr got=%b exp=0", ovf_err); end
    for (int i = 0; i < 15; i++) cyc(0, 1, 0, 8'h00, 0);
    checks++; if (dout !== 8'h00 || empty !== 1'b1 || udf_err !== 1'b0) begin failures++; $display("FAIL drain dout=%h empty=%b udf=%b exp=00/1/0", dout, empty, udf_err); end
  endtask

  task automatic test_replace;
    cyc(1, 0, 0, 8'h10, 0);
    cyc(1, 0, 0, 8'h20, 0);
    cyc(1, 1, 0, 8'h99, 0);
    checks++; if (dout !== 8'h20 || count !== 5'd2) begin failures++; $display("FAIL repl dout=%h count=%0d exp=20/2", dout, count); end
    cyc(0, 1, 0, 8'h00, 0);
    checks++; if (dout !== 8'h99) begin failures++; $display("FAIL repl_pop got=%h exp=99", dout); end
    cyc(0, 1, 0, 8'h00, 0);
    checks++; if (dout !== 8'h10 || empty !== 1'b1) begin failures++; $display("FAIL repl_pop2 dout=%h empty=%b exp=10/1", dout, empty); end
    // push&pop on an empty stack: underflow, plain push, dout held.
    cyc(1, 1, 0, 8'h77, 0);
    checks++; if (udf_err !== 1'b1 || count !== 5'd1 || dout !== 8'h10) begin failures++; $display("FAIL repl_empty udf=%b count=%0d dout=%h exp=1/1/10", udf_err, count, dout); end
    cyc(0, 1, 0, 8'h00, 1);
    checks++; if (dout !== 8'h77 || udf_err !== 1'b0) begin failures++; $display("FAIL repl_empty_pop dout=%h udf=%b exp=77/0", dout, udf_err); end
  endtask

  task automatic test_tos_push;
    cyc(1, 0, 0, 8'h31, 0);
    cyc(1, 0, 1, 8'h42, 0);
    checks++; if (dout !== 8'h31 || count !== 5'd2) begin failures++; $display("FAIL tos_push dout=%h count=%0d exp=31/2", dout, count); end
    cyc(0, 1, 0, 8'h00, 0);
    checks++; if (dout !== 8'h42) begin failures++; $display("FAIL tos_push_pop1 got=%h exp=42", dout); end
    cyc(0, 1, 0, 8'h00, 0);
    checks++; if (dout !== 8'h31 || empty !== 1'b1) begin failures++; $display("FAIL tos_push_pop2 dout=%h empty=%b exp=31/1", dout, empty); end
  endtask

  task automatic test_reset_mid;
    cyc(1, 0, 0, 8'h44, 0);
    cyc(1, 0, 0, 8'h55, 0);
    pop = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (dout !== 8'h00 || count !== 5'd0 || empty !== 1'b1) begin failures++; $display("FAIL rst_mid dout=%h count=%0d empty=%b exp=00/0/1", dout, count, empty); end
    pop = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    cyc(0, 1, 0, 8'h00, 0);
    checks++; if (udf_err !== 1'b1 || count !== 5'd0 || dout !== 8'h00) begin failures++; $display("FAIL rst_mid_pop udf=%b count=%0d dout=%h exp=1/0/00", udf_err, count, dout); end
  endtask

  initial begin
    test_reset();
    test_push_pop();
    test_tos();
    test_underflow();
    test_full();
    test_replace();
    test_tos_push();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
